// File: rtl/fifo_wptr_ctrl.sv
// Write-domain half of the async FIFO: owns the write pointer, publishes it in Gray code,
// and turns the synchronised read pointer into full / almost_full / fill-count flags.
module fifo_wptr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  wclk_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic                  clr_overflow,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] AF_TH = (AW+1)'(AFULL_THRESH);

  logic [SYNC_STAGES-1:0][AW:0] sync_q;
  logic [AW:0] wbin, wbin_next, wgray_next;
  logic [AW:0] rq_gray, rq_bin, full_tgt, fill_next;
  logic        wr_acc;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rptr_gray};
  end

  assign rq_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    rq_bin = '0;
    for (int i = 0; i <= AW; i++) rq_bin[i] = ^(rq_gray >> i);
  end

  // Same qualifier the memory uses, so pointer and data never disagree.
  assign wr_acc     = wclk_en & ~full;
  assign wbin_next  = wbin + {{AW{1'b0}}, wr_acc};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign full_tgt   = {~rq_gray[AW:AW-1], rq_gray[AW-2:0]};
  assign fill_next  = wbin_next - rq_bin;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin        <= '0;
      waddr       <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      waddr       <= wbin_next[AW-1:0];
      wptr_gray   <= wgray_next;
      full        <= (wgray_next == full_tgt);
      almost_full <= (fill_next >= AF_TH);
      wr_count    <= fill_next;
      overflow    <= (wclk_en & full) | (overflow & ~clr_overflow);
    end
  end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed bench for fifo_wptr_ctrl: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_fifo_wptr_ctrl;

  logic       wclk = 1'b0, wrst = 1'b1, wclk_en = 1'b0, clr_overflow = 1'b0;
  logic [4:0] rptr_gray = '0;
  logic [3:0] waddr;
  logic [4:0] wptr_gray, wr_count;
  logic       full, almost_full, overflow;

  fifo_wptr_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12), .SYNC_STAGES(2)) dut (
    .wclk(wclk), .wrst(wrst), .wclk_en(wclk_en), .rptr_gray(rptr_gray),
    .clr_overflow(clr_overflow), .waddr(waddr), .wptr_gray(wptr_gray), .full(full),
    .almost_full(almost_full), .wr_count(wr_count), .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  int cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [3:0] waddr;
    logic [4:0] wg;
    logic       full;
    logic       af;
    logic [4:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  logic [4:0] prev_g = '0;

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic push_exp(input string nm, input int wa, input int wg, input logic f,
                          input logic af, input int cnt, input logic ov);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.waddr = 4'(wa); e.wg = 5'(wg);
    e.full = f; e.af = af; e.cnt = 5'(cnt); e.ovf = ov;
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s @cycle %0d: got %0d, expected %0d", nm, fld, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge wclk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc != cyc) begin
          checks++; errors++;
          $display("FAIL %s stale: due cycle %0d, seen at %0d", e.nm, e.cyc, cyc);
        end else begin
          cmp(e.nm, "waddr",       int'(waddr),       int'(e.waddr));
          cmp(e.nm, "wptr_gray",   int'(wptr_gray),   int'(e.wg));
          cmp(e.nm, "full",        int'(full),        int'(e.full));
          cmp(e.nm, "almost_full", int'(almost_full), int'(e.af));
          cmp(e.nm, "wr_count",    int'(wr_count),    int'(e.cnt));
          cmp(e.nm, "overflow",    int'(overflow),    int'(e.ovf));
        end
      end
      // Gray pointer leaving the domain must only ever move one bit at a time.
      if (!wrst && wptr_gray != prev_g)
        cmp("gray_step", "bits_changed", $countones(wptr_gray ^ prev_g), 1);
      prev_g = wptr_gray;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int wb;
    // Reset state
    tick; push_exp("reset", 0, 0, 0, 0, 0, 0);
    tick; push_exp("reset", 0, 0, 0, 0, 0, 0);
    wrst = 1'b0;
    tick; push_exp("idle", 0, 0, 0, 0, 0, 0);

    // Fill: almost_full at count 12, full at 16 with wptr_gray 11000
    wclk_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick;
      push_exp("fill", k % 16, g(k), k == 16, k >= 12, k, 0);
    end

    // Overflow: write while full, set beats clear, then clear alone
    tick; push_exp("ovf_set", 0, 5'b11000, 1, 1, 16, 1);
    clr_overflow = 1'b1;
    tick; push_exp("ovf_set_wins", 0, 5'b11000, 1, 1, 16, 1);
    wclk_en = 1'b0;
    tick; push_exp("ovf_clr", 0, 5'b11000, 1, 1, 16, 0);
    clr_overflow = 1'b0;

    // Drain visibility: reader to 4, seen exactly on the third edge
    rptr_gray = 5'b00110;
    tick; push_exp("drain_e1", 0, 5'b11000, 1, 1, 16, 0);
    tick; push_exp("drain_e2", 0, 5'b11000, 1, 1, 16, 0);
    tick; push_exp("drain_e3", 0, 5'b11000, 0, 1, 12, 0);

    // Wrap: 40 writes, reader keeps pace (count settles at 6 once the sync catches up)
    wclk_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      rptr_gray = g((12 + k) % 32);
      tick;
      wb = (16 + k) % 32;
      push_exp("wrap", wb % 16, g(wb), 0, k <= 2, (k == 1) ? 13 : ((k == 2) ? 14 : 6), 0);
    end

    // Settle to count 4, then write up to count 7
    wclk_en = 1'b0;
    tick; push_exp("settle", 8, 5'b10100, 0, 0, 5, 0);
    tick; push_exp("settle", 8, 5'b10100, 0, 0, 4, 0);
    tick; push_exp("settle", 8, 5'b10100, 0, 0, 4, 0);
    wclk_en = 1'b1;
    tick; push_exp("refill", 9,  5'b10101, 0, 0, 5, 0);
    tick; push_exp("refill", 10, 5'b10111, 0, 0, 6, 0);
    tick; push_exp("refill", 11, 5'b10110, 0, 0, 7, 0);

    // Async reset between edges with wr_count=7
    wclk_en = 1'b0;
    tick; #1;
    wrst = 1'b1;
    rptr_gray = '0;
    push_exp("rst_async", 0, 0, 0, 0, 0, 0);
    tick; push_exp("rst_hold", 0, 0, 0, 0, 0, 0);
    wrst = 1'b0;
    tick; push_exp("post_rst", 0, 0, 0, 0, 0, 0);
    wclk_en = 1'b1;
    tick; push_exp("post_rst_wr", 1, 1, 0, 0, 1, 0);
    wclk_en = 1'b0;
    tick; push_exp("post_rst_idle", 1, 1, 0, 0, 1, 0);

    tick; tick;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover: got %0d unchecked expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
